// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with a
// valid/ready handshake, bubble collapsing and a tag carried alongside each op.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [1:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic [1:0]       op_q    [SHW];
  logic [1:0]       op_d    [SHW];
  logic [SHW-1:0]   sign_q, sign_d;
  logic [TAG_W-1:0] tag_q   [SHW];
  logic [TAG_W-1:0] tag_d   [SHW];

  logic [SHW-1:0]   adv_s;
  logic [SHW-1:0]   src_valid_s;
  logic [SHW-1:0]   src_sign_s;
  logic [WIDTH-1:0] src_data_s  [SHW];
  logic [SHW-1:0]   src_shamt_s [SHW];
  logic [1:0]       src_op_s    [SHW];
  logic [TAG_W-1:0] src_tag_s   [SHW];

  // Fixed-distance shift for one stage; sign is the operand's original MSB.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] r;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = (d >> amt) | (sign ? fill_mask : {WIDTH{1'b0}});
      OP_SLL:  r = d << amt;
      OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  // Ready chain from the output back to the input; each stage may advance if
  // it is empty or everything downstream of it can move.
  always_comb begin
    logic nxt;
    nxt = out_ready | ~valid_q[SHW-1];
    adv_s[SHW-1] = nxt;
    for (int k = SHW - 2; k >= 0; k--) begin
      nxt = ~valid_q[k] | nxt;
      adv_s[k] = nxt;
    end
  end

  assign in_ready = adv_s[0];

  // Upstream source for every stage: the input port for stage 0.
  always_comb begin
    src_valid_s[0] = in_valid;
    src_data_s[0]  = in_data;
    src_shamt_s[0] = in_shamt;
    src_op_s[0]    = in_op;
    src_sign_s[0]  = in_data[WIDTH-1];
    src_tag_s[0]   = in_tag;
    for (int k = 1; k < SHW; k++) begin
      src_valid_s[k] = valid_q[k-1];
      src_data_s[k]  = data_q[k-1];
      src_shamt_s[k] = shamt_q[k-1];
      src_op_s[k]    = op_q[k-1];
      src_sign_s[k]  = sign_q[k-1];
      src_tag_s[k]   = tag_q[k-1];
    end
  end

  // Stage next-state: load from upstream on advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    sign_d  = sign_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    for (int k = 0; k < SHW; k++) begin
      if (adv_s[k]) begin
        valid_d[k] = src_valid_s[k];
        if (src_valid_s[k]) begin
          data_d[k]  = src_shamt_s[k][k]
                       ? stage_shift(src_data_s[k], src_op_s[k], src_sign_s[k], 32'd1 << k)
                       : src_data_s[k];
          shamt_d[k] = src_shamt_s[k];
          op_d[k]    = src_op_s[k];
          sign_d[k]  = src_sign_s[k];
          tag_d[k]   = src_tag_s[k];
        end else begin
          data_d[k]  = data_q[k];
          shamt_d[k] = shamt_q[k];
          op_d[k]    = op_q[k];
          sign_d[k]  = sign_q[k];
          tag_d[k]   = tag_q[k];
        end
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Stage registers; reset clears every valid bit and the output fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {SHW{1'b0}};
      sign_q  <= {SHW{1'b0}};
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= {WIDTH{1'b0}};
        shamt_q[k] <= {SHW{1'b0}};
        op_q[k]    <= 2'b00;
        tag_q[k]   <= {TAG_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and random checks of shift_pipe at WIDTH=32, TAG_W=4.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] d; logic [3:0] t; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [63:0] dd;
    case (op)
      2'b00:   return d >> s;
      2'b01:   return $unsigned($signed(d) >>> s);
      2'b10:   return d << s;
      default: begin dd = {d, d} >> s; return dd[31:0]; end
    endcase
  endfunction

  // One clock: drive at negedge, sample handshakes just after, then take the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s,
                      input logic [1:0] op, input logic [3:0] tag, input logic ordy,
                      output logic acc, output logic outv, output logic got,
                      output logic [31:0] od, output logic [3:0] ot);
    @(negedge clk);
    in_valid = v; in_data = d; in_shamt = s; in_op = op; in_tag = tag; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    outv = out_valid;
    got = out_valid && out_ready;
    od = out_data;
    ot = out_tag;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = 32'hFFFF_FFFF; in_shamt = 5'd0; in_op = 2'b00; in_tag = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++;
    if (out_tag !== 4'h0) begin n_bad++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [16] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2,
                               2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1};
    logic [31:0] t_d  [16] = '{32'h8000_0000, 32'h8000_0000, 32'h7000_0000, 32'h0000_0001,
                               32'h0000_0001, 32'h1234_5678, 32'hF0F0_F0F0, 32'h1234_5678,
                               32'h8000_0000, 32'h8000_0001, 32'hDEAD_BEEF, 32'h8000_0001,
                               32'h8000_0001, 32'hDEAD_BEEF, 32'hC300_0000, 32'h4000_0000};
    logic [4:0]  t_s  [16] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd1, 5'd8, 5'd4, 5'd4,
                               5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd21, 5'd30};
    logic [31:0] t_e  [16] = '{32'h0000_0001, 32'hF800_0000, 32'h0700_0000, 32'h8000_0000,
                               32'h8000_0000, 32'h7812_3456, 32'h0F0F_0F0F, 32'h2345_6780,
                               32'hFFFF_FFFF, 32'h0000_0003, 32'hDEAD_BEEF, 32'h8000_0001,
                               32'h8000_0001, 32'hDEAD_BEEF, 32'hFFFF_FE18, 32'h0000_0001};
    logic acc, outv, got;
    logic [31:0] od;
    logic [3:0] ot;
    int lat;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, t_d[i], t_s[i], t_op[i], 4'(i), 1'b1, acc, outv, got, od, ot);
      n_cmp++;
      if (acc !== 1'b1) begin n_bad++; $display("FAIL dir_accept[%0d] got %b want 1", i, acc); end
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        step(1'b0, 32'h5A5A_5A5A, 5'd7, 2'd3, 4'hA, 1'b1, acc, outv, got, od, ot);
        if (got) begin lat = c; break; end
      end
      n_cmp++;
      if (lat != 5) begin n_bad++; $display("FAIL dir_latency[%0d] got %0d want 5", i, lat); end
      n_cmp++;
      if (od !== t_e[i]) begin n_bad++; $display("FAIL dir_data[%0d] got %h want %h", i, od, t_e[i]); end
      n_cmp++;
      if (ot !== 4'(i)) begin n_bad++; $display("FAIL dir_tag[%0d] got %h want %h", i, ot, 4'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, outv, got;
    logic [31:0] od, d;
    logic [3:0] ot;
    logic [4:0] s;
    int n_acc = 0, n_got = 0, prev = -1;
    exp_t e;
    q.delete();
    for (int c = 0; c < 45; c++) begin
      d = 32'h9E37_79B9 * (c + 1);
      s = 5'((c * 7) % 32);
      if (c < 20) begin
        step(1'b1, d, s, 2'(c % 4), 4'(c % 16), 1'b1, acc, outv, got, od, ot);
        if (acc) begin
          q.push_back('{d: ref_shift(2'(c % 4), d, s), t: 4'(c % 16)});
          n_acc++;
        end
      end else begin
        step(1'b0, d, s, 2'(c % 4), 4'(c % 16), 1'b1, acc, outv, got, od, ot);
      end
      if (got) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra got %h want none", od);
        end else begin
          e = q.pop_front();
          if (od !== e.d || ot !== e.t) begin
            n_bad++; $display("FAIL b2b_result[%0d] got %h/%h want %h/%h", n_got, od, ot, e.d, e.t);
          end
        end
        if (prev >= 0) begin
          n_cmp++;
          if (c != prev + 1) begin n_bad++; $display("FAIL b2b_gap got cycle %0d want %0d", c, prev + 1); end
        end
        prev = c;
        n_got++;
      end
    end
    n_cmp++;
    if (n_acc != 20) begin n_bad++; $display("FAIL b2b_accepts got %0d want 20", n_acc); end
    n_cmp++;
    if (n_got != 20) begin n_bad++; $display("FAIL b2b_results got %0d want 20", n_got); end
  endtask

  task automatic test_fill_stall();
    logic acc, outv, got, held = 1'b0;
    logic [31:0] od, d, hd = 32'h0;
    logic [3:0] ot, ht = 4'h0;
    int n_acc = 0, n_got = 0;
    exp_t e;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      d = 32'hA5A5_0000 + 32'(i * 32'h0101_0101);
      step(1'b1, d, 5'(i + 1), 2'(i % 4), 4'(i + 1), 1'b0, acc, outv, got, od, ot);
      if (acc) begin
        q.push_back('{d: ref_shift(2'(i % 4), d, 5'(i + 1)), t: 4'(i + 1)});
        n_acc++;
      end
      if (outv) begin
        if (held) begin
          n_cmp++;
          if (od !== hd || ot !== ht) begin
            n_bad++; $display("FAIL stall_stable got %h/%h want %h/%h", od, ot, hd, ht);
          end
        end else begin
          hd = od; ht = ot; held = 1'b1;
        end
      end
    end
    n_cmp++;
    if (n_acc != 5) begin n_bad++; $display("FAIL fill_accepts got %0d want 5", n_acc); end
    n_cmp++;
    if (acc !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got %b want 0", acc); end
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 32'h0, 5'd0, 2'd0, 4'h0, 1'b1, acc, outv, got, od, ot);
      if (got) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL drain_extra got %h want none", od);
        end else begin
          e = q.pop_front();
          if (od !== e.d || ot !== e.t) begin
            n_bad++; $display("FAIL drain_result[%0d] got %h/%h want %h/%h", n_got, od, ot, e.d, e.t);
          end
        end
        n_got++;
      end
    end
    n_cmp++;
    if (n_got != 5) begin n_bad++; $display("FAIL drain_count got %0d want 5", n_got); end
  endtask

  task automatic test_reset_midflight();
    logic acc, outv, got;
    logic [31:0] od;
    logic [3:0] ot;
    int n_got = 0, lat = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h1111_1111 * (i + 1), 5'd3, 2'd2, 4'(i + 5), 1'b1, acc, outv, got, od, ot);
    end
    step(1'b0, 32'h0, 5'd0, 2'd0, 4'h0, 1'b0, acc, outv, got, od, ot);
    step(1'b0, 32'h0, 5'd0, 2'd0, 4'h0, 1'b0, acc, outv, got, od, ot);
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid got %b want 1", out_valid); end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    q.delete();
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 32'h0, 5'd0, 2'd0, 4'h0, 1'b1, acc, outv, got, od, ot);
      if (outv) n_got++;
    end
    n_cmp++;
    if (n_got != 0) begin n_bad++; $display("FAIL midrst_stale got %0d results want 0", n_got); end
    step(1'b1, 32'h8765_4321, 5'd12, 2'd3, 4'hC, 1'b1, acc, outv, got, od, ot);
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 32'h0, 5'd0, 2'd0, 4'h0, 1'b1, acc, outv, got, od, ot);
      if (got) begin lat = c; break; end
    end
    n_cmp++;
    if (lat != 5) begin n_bad++; $display("FAIL midrst_next_latency got %0d want 5", lat); end
    n_cmp++;
    if (od !== 32'h3218_7654 || ot !== 4'hC) begin
      n_bad++; $display("FAIL midrst_next_result got %h/%h want 32187654/c", od, ot);
    end
  endtask

  task automatic test_random();
    logic acc, outv, got, v, ordy, prev_stall = 1'b0;
    logic [31:0] od, d, pd = 32'h0;
    logic [3:0] ot, tg, pt = 4'h0;
    logic [4:0] s;
    logic [1:0] op;
    int sent = 0, recv = 0, cyc = 0;
    exp_t e;
    q.delete();
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      v    = ($urandom_range(3) != 0) && (sent < 10000);
      ordy = ($urandom_range(9) < 7) || (sent >= 10000);
      d    = $urandom;
      s    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      op   = 2'($urandom);
      tg   = 4'($urandom);
      step(v, d, s, op, tg, ordy, acc, outv, got, od, ot);
      if (prev_stall) begin
        n_cmp++;
        if (outv !== 1'b1 || od !== pd || ot !== pt) begin
          n_bad++; $display("FAIL rnd_stall_stable got %b/%h/%h want 1/%h/%h", outv, od, ot, pd, pt);
        end
      end
      prev_stall = outv && !ordy;
      pd = od; pt = ot;
      if (acc) begin
        q.push_back('{d: ref_shift(op, d, s), t: tg});
        sent++;
      end
      if (got) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra got %h want none", od);
        end else begin
          e = q.pop_front();
          if (od !== e.d || ot !== e.t) begin
            n_bad++; $display("FAIL rnd_result[%0d] got %h/%h want %h/%h", recv, od, ot, e.d, e.t);
          end
        end
        recv++;
      end
      cyc++;
    end
    n_cmp++;
    if (recv != 10000) begin n_bad++; $display("FAIL rnd_count got %0d want 10000", recv); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_fill_stall();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 Derived constant SHW = log2(WIDTH), default 5; shift-amount width and pipeline depth.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid && in_ready at a rising edge.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  SHW  shift amount, unsigned.
REQ-010 in_op  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 ROR (rotate right).
REQ-011 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge.
REQ-014 out_data  output  WIDTH  shifted result.
REQ-015 out_tag  output  TAG_W  tag of the operation producing out_data.

Function
REQ-016 The block SHALL be a pipeline of SHW registered stages; stage k (k = 0..SHW-1) SHALL shift by 2^k when shamt bit k is 1, and pass the value through unchanged otherwise.
REQ-017 Each stage SHALL hold: valid, data, remaining shamt bits, op and tag; out_* SHALL be driven directly from the last stage's registers.
REQ-018 SRL fill SHALL be 0; SRA fill SHALL be the operand's original bit WIDTH-1, captured at acceptance; SLL fill SHALL be 0 on the right; ROR SHALL wrap bits shifted out of bit 0 into bit WIDTH-1.
REQ-019 Shift amount 0 SHALL return in_data unchanged for every op.
REQ-020 Latency SHALL be exactly SHW cycles from acceptance to out_valid when there is no backpressure (5 for WIDTH=32).
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-022 Stage k SHALL advance when stage k+1 is empty or advancing; the last stage advances when out_ready=1 or it is empty; in_ready SHALL equal stage-0 empty or stage-0 advancing (combinational ready chain).
REQ-023 A stalled stage SHALL hold all of its fields stable; out_data/out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Bubbles SHALL collapse: an empty stage SHALL accept from its upstream neighbour even if downstream stages are stalled.
REQ-025 Simultaneous output handshake and input handshake in one cycle SHALL both complete, with no loss or duplication.
REQ-026 Operations SHALL leave in acceptance order; the pipeline SHALL hold at most SHW operations.
REQ-027 in_data/in_shamt/in_op/in_tag SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-028 While rst_n=0, all stage valid bits SHALL be 0; out_valid SHALL be 0 and in_ready SHALL be 1 once reset is released.
REQ-029 out_data and out_tag SHALL reset to 0; other stage data fields need no reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after release.

Verification
REQ-031 WIDTH=32, out_ready=1; SRL 0x80000000 by 31 -> out_data=0x00000001 exactly 5 cycles later, with tag preserved.
REQ-032 SRA 0x80000000 by 4 -> 0xF8000000; SRA 0x70000000 by 4 -> 0x07000000; SLL 0x00000001 by 31 -> 0x80000000; ROR 0x00000001 by 1 -> 0x80000000.
REQ-033 Back-to-back stream of 20 ops with tags 0..15,0..3 -> 20 results in order, one per cycle, all values matching the reference model.
REQ-034 Fill the pipe with out_ready=0 -> in_ready=0 after 5 accepts; out_data stable; release out_ready -> 5 results drain in order with no loss.
REQ-035 Drop rst_n with 3 ops in flight -> out_valid=0 immediately; no stale result appears after release; the next op completes normally.
REQ-036 Random op/shamt/data with random out_ready, 10k ops -> scoreboard match; shamt=0 returns the operand unchanged for all four ops.
